// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: one-hot state encodings and parity modes.
package uart_pkg;

  localparam int NB_STATE = 5;

  localparam logic [NB_STATE-1:0] ST_IDLE   = 5'b00001;
  localparam logic [NB_STATE-1:0] ST_START  = 5'b00010;
  localparam logic [NB_STATE-1:0] ST_DATA   = 5'b00100;
  localparam logic [NB_STATE-1:0] ST_PARITY = 5'b01000;
  localparam logic [NB_STATE-1:0] ST_STOP   = 5'b10000;

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clock,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset_i) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with parity/framing error reporting and break lockout.
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchronizer first.
module uart_rx_cfg #(
  parameter int N_DATA      = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int N_STOP      = 1
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              rx,
  input  logic              s_tick,
  output logic [N_DATA-1:0] dout,
  output logic              rx_done_tick,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(N_DATA) + 1;

  localparam logic [TW-1:0] T_MID       = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END       = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(N_DATA - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(N_STOP - 1);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .clock  (clock),
    .reset_i(reset_i),
    .d      (rx),
    .q      (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  state_t            state_q, state_n;
  logic [TW-1:0]     tick_q, tick_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic [N_DATA-1:0] sr_q, sr_n;
  logic              perr_q, perr_n;
  logic              ferr_q, ferr_n;
  logic              armed_q, armed_n;
  logic              done_n;
  logic [N_DATA-1:0] dout_n;
  logic              par_out_n, fr_out_n;
  logic              stop_fail;

  assign stop_fail = ferr_q | ~rx_s;

  always_comb begin
    state_n   = state_q;
    tick_n    = tick_q;
    bit_n     = bit_q;
    sr_n      = sr_q;
    perr_n    = perr_q;
    ferr_n    = ferr_q;
    armed_n   = armed_q;
    done_n    = 1'b0;
    dout_n    = dout;
    par_out_n = parity_err;
    fr_out_n  = frame_err;

    case (state_q)
      S_IDLE: begin
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (armed_q) begin
          state_n = S_START;
          tick_n  = '0;
        end
      end

      S_START: begin
        if (s_tick) begin
          if (tick_q == T_MID) begin
            if (!rx_s) begin
              state_n = S_DATA;
              tick_n  = '0;
              bit_n   = '0;
              perr_n  = 1'b0;
              ferr_n  = 1'b0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (s_tick) begin
          if (tick_q == T_END) begin
            tick_n = '0;
            sr_n   = {rx_s, sr_q[N_DATA-1:1]};
            if (bit_q == B_DATA_LAST) begin
              bit_n   = '0;
              state_n = (PARITY_MODE != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              bit_n = bit_q + 1'b1;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (s_tick) begin
          if (tick_q == T_END) begin
            tick_n  = '0;
            perr_n  = (^sr_q) ^ rx_s ^ (PARITY_MODE == PAR_ODD);
            state_n = S_STOP;
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (s_tick) begin
          if (tick_q == T_END) begin
            tick_n = '0;
            ferr_n = stop_fail;
            if (bit_q == B_STOP_LAST) begin
              // Completion is registered here so all outputs update together one clock later.
              bit_n     = '0;
              state_n   = S_IDLE;
              done_n    = 1'b1;
              dout_n    = sr_q;
              par_out_n = perr_q;
              fr_out_n  = stop_fail;
              if (stop_fail) armed_n = 1'b0;
            end else begin
              bit_n = bit_q + 1'b1;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_n;
      tick_q       <= tick_n;
      bit_q        <= bit_n;
      sr_q         <= sr_n;
      perr_q       <= perr_n;
      ferr_q       <= ferr_n;
      armed_q      <= armed_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      parity_err   <= par_out_n;
      frame_err    <= fr_out_n;
      busy         <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) driven with line-level frames
// and compared against a frame-level model of the expected word and error flags.
module tb_uart_rx_cfg;

  import uart_pkg::*;

  localparam int BIT = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic clock = 1'b0;
  logic reset_i = 1'b1;
  logic s_tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] dout_a, dout_b, dout_c;
  logic done_a, done_b, done_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  int checks = 0;
  int failures = 0;
  int busy_ticks = 0;
  logic [7:0] last_a;

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] q_c[$];
  logic [9:0] exp_q[$];

  always #5 clock = ~clock;

  uart_rx_cfg #(.N_DATA(8), .OVERSAMPLE(16), .PARITY_MODE(0), .N_STOP(1)) dut_a (
    .clock(clock), .reset_i(reset_i), .rx(rx_a), .s_tick(s_tick), .dout(dout_a),
    .rx_done_tick(done_a), .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

  uart_rx_cfg #(.N_DATA(8), .OVERSAMPLE(16), .PARITY_MODE(1), .N_STOP(1)) dut_b (
    .clock(clock), .reset_i(reset_i), .rx(rx_b), .s_tick(s_tick), .dout(dout_b),
    .rx_done_tick(done_b), .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b));

  uart_rx_cfg #(.N_DATA(8), .OVERSAMPLE(16), .PARITY_MODE(0), .N_STOP(2)) dut_c (
    .clock(clock), .reset_i(reset_i), .rx(rx_c), .s_tick(s_tick), .dout(dout_c),
    .rx_done_tick(done_c), .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c));

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clock);
      #1;
      tc = (tc + 1) % 4;
      s_tick = (tc == 0);
    end
  end

  always @(negedge clock) begin
    if (done_a) q_a.push_back({perr_a, ferr_a, dout_a});
    if (done_b) q_b.push_back({perr_b, ferr_b, dout_b});
    if (done_c) q_c.push_back({perr_c, ferr_c, dout_c});
    if (busy_a && s_tick) busy_ticks++;
  end

  // Expected {parity_err, frame_err, dout} for one frame, from counts of ones on the line.
  function automatic logic [9:0] model(input logic [7:0] data, input int mode, input logic pbit,
                                       input int nstop, input logic [1:0] stops);
    int ones;
    logic pe, fe;
    ones = $countones(data) + int'(pbit);
    case (mode)
      PAR_EVEN: pe = (ones % 2) == 1;
      PAR_ODD:  pe = (ones % 2) == 0;
      default:  pe = 1'b0;
    endcase
    fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    return {pe, fe, data};
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_rx(sel, v);
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input int use_par,
                            input logic pbit, input int nstop, input logic [1:0] stops);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (use_par != 0) drive_bit(sel, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stops[i]);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (dout_a !== 8'h00) begin failures++; $display("FAIL reset_dout_a: got %h expected 00", dout_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
    checks++; if (perr_a !== 1'b0) begin failures++; $display("FAIL reset_perr_a: got %b expected 0", perr_a); end
    checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL reset_ferr_a: got %b expected 0", ferr_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    checks++; if (perr_b !== 1'b0) begin failures++; $display("FAIL reset_perr_b: got %b expected 0", perr_b); end
    checks++; if (ferr_c !== 1'b0) begin failures++; $display("FAIL reset_ferr_c: got %b expected 0", ferr_c); end
    @(posedge clock); #1;
    reset_i = 1'b0;
    repeat (BIT) @(posedge clock);
    #1;
  endtask

  task automatic test_8n1();
    q_a.delete();
    busy_ticks = 0;
    send_frame(0, 8'hA5, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1);
    checks++; if (q_a.size() != 1) begin failures++; $display("FAIL 8n1_pulses: got %0d expected 1", q_a.size()); end
    if (q_a.size() >= 1) begin
      checks++;
      if (q_a[0] !== model(8'hA5, PAR_NONE, 1'b0, 1, 2'b11)) begin
        failures++; $display("FAIL 8n1_word: got %h expected %h", q_a[0], model(8'hA5, PAR_NONE, 1'b0, 1, 2'b11));
      end
    end
    checks++; if (busy_ticks != 8 + 16 * 9) begin failures++; $display("FAIL 8n1_busy_ticks: got %0d expected %0d", busy_ticks, 8 + 16 * 9); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL 8n1_busy_idle: got %b expected 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    q_a.delete();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      exp_q.push_back(model(d, PAR_NONE, 1'b0, 1, 2'b11));
      send_frame(0, d, 0, 1'b0, 1, 2'b11);
      last_a = d;
    end
    drive_bit(0, 1'b1);
    checks++; if (q_a.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", q_a.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_a.size(); k++) begin
      checks++;
      if (q_a[k] !== exp_q[k]) begin failures++; $display("FAIL b2b_word%0d: got %h expected %h", k, q_a[k], exp_q[k]); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic p;
    q_b.delete();
    exp_q.delete();
    send_frame(1, 8'h3C, 1, 1'b1, 1, 2'b11);
    exp_q.push_back(model(8'h3C, PAR_EVEN, 1'b1, 1, 2'b11));
    drive_bit(1, 1'b1);
    send_frame(1, 8'h3C, 1, 1'b0, 1, 2'b11);
    exp_q.push_back(model(8'h3C, PAR_EVEN, 1'b0, 1, 2'b11));
    drive_bit(1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      send_frame(1, d, 1, p, 1, 2'b11);
      exp_q.push_back(model(d, PAR_EVEN, p, 1, 2'b11));
    end
    drive_bit(1, 1'b1);
    checks++; if (q_b.size() != exp_q.size()) begin failures++; $display("FAIL par_count: got %0d expected %0d", q_b.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_b.size(); k++) begin
      checks++;
      if (q_b[k] !== exp_q[k]) begin failures++; $display("FAIL par_word%0d: got %h expected %h", k, q_b[k], exp_q[k]); end
    end
  endtask

  task automatic test_stop2();
    logic [7:0] d;
    logic [1:0] s;
    q_c.delete();
    exp_q.delete();
    send_frame(2, 8'h5A, 0, 1'b0, 2, 2'b01);
    exp_q.push_back(model(8'h5A, PAR_NONE, 1'b0, 2, 2'b01));
    drive_bit(2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      s = (k < 2) ? 2'b11 : 2'($urandom);
      send_frame(2, d, 0, 1'b0, 2, s);
      exp_q.push_back(model(d, PAR_NONE, 1'b0, 2, s));
      drive_bit(2, 1'b1);
    end
    checks++; if (q_c.size() != exp_q.size()) begin failures++; $display("FAIL stop2_count: got %0d expected %0d", q_c.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_c.size(); k++) begin
      checks++;
      if (q_c[k] !== exp_q[k]) begin failures++; $display("FAIL stop2_word%0d: got %h expected %h", k, q_c[k], exp_q[k]); end
    end
  endtask

  task automatic test_glitch();
    q_a.delete();
    rx_a = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    rx_a = 1'b1;
    repeat (3 * BIT) @(posedge clock);
    @(negedge clock);
    checks++; if (q_a.size() != 0) begin failures++; $display("FAIL glitch_pulses: got %0d expected 0", q_a.size()); end
    checks++; if (dout_a !== last_a) begin failures++; $display("FAIL glitch_dout: got %h expected %h", dout_a, last_a); end
    checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL glitch_ferr: got %b expected 0", ferr_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_busy: got %b expected 0", busy_a); end
    @(posedge clock); #1;
  endtask

  task automatic test_break();
    q_a.delete();
    rx_a = 1'b0;
    repeat (30 * BIT) @(posedge clock);
    @(negedge clock);
    checks++; if (q_a.size() != 1) begin failures++; $display("FAIL break_pulses: got %0d expected 1", q_a.size()); end
    if (q_a.size() >= 1) begin
      checks++;
      if (q_a[0] !== model(8'h00, PAR_NONE, 1'b0, 1, 2'b00)) begin
        failures++; $display("FAIL break_word: got %h expected %h", q_a[0], model(8'h00, PAR_NONE, 1'b0, 1, 2'b00));
      end
    end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL break_busy: got %b expected 0", busy_a); end
    @(posedge clock); #1;
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    send_frame(0, 8'h81, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1);
    checks++; if (q_a.size() != 2) begin failures++; $display("FAIL break_recover_count: got %0d expected 2", q_a.size()); end
    if (q_a.size() >= 2) begin
      checks++;
      if (q_a[1] !== model(8'h81, PAR_NONE, 1'b0, 1, 2'b11)) begin
        failures++; $display("FAIL break_recover_word: got %h expected %h", q_a[1], model(8'h81, PAR_NONE, 1'b0, 1, 2'b11));
      end
    end
  endtask

  task automatic test_reset_mid();
    q_a.delete();
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    repeat (BIT / 2) @(posedge clock);
    @(negedge clock);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy_a); end
    @(posedge clock); #1;
    reset_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (dout_a !== 8'h00) begin failures++; $display("FAIL midreset_dout: got %h expected 00", dout_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b expected 0", done_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy_a); end
    checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL midreset_ferr: got %b expected 0", ferr_a); end
    @(posedge clock); #1;
    reset_i = 1'b0;
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    checks++; if (q_a.size() != 0) begin failures++; $display("FAIL midreset_pulses: got %0d expected 0", q_a.size()); end
    send_frame(0, 8'hFF, 0, 1'b0, 1, 2'b11);
    drive_bit(0, 1'b1);
    checks++; if (q_a.size() != 1) begin failures++; $display("FAIL midreset_next_count: got %0d expected 1", q_a.size()); end
    if (q_a.size() >= 1) begin
      checks++;
      if (q_a[0] !== model(8'hFF, PAR_NONE, 1'b0, 1, 2'b11)) begin
        failures++; $display("FAIL midreset_next_word: got %h expected %h", q_a[0], model(8'hFF, PAR_NONE, 1'b0, 1, 2'b11));
      end
    end
  endtask

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_8n1();
    test_back_to_back();
    test_parity();
    test_stop2();
    test_glitch();
    test_break();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver in the debug/loader path of the MIPS FPGA design. It oversamples `rx` on `s_tick` enables from the shared baud generator. Data width, parity mode, stop-bit count and oversampling ratio are set by parameters. It reports framing and parity errors alongside each received word, and suppresses re-triggering on a held-low (break) line.

## Interface
Parameters:
- `N_DATA`, 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit; even, ≥4.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `N_STOP`, 1: stop bits checked; 1 or 2.

Ports:
- `clock`  in  1: single clock; all logic on its rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `rx`  in  1: serial line, idle high.
- `s_tick`  in  1: one-cycle oversample enable.
- `dout`  out  N_DATA: last received word, LSB first on the line.
- `rx_done_tick`  out  1: one-cycle pulse; a frame has completed.
- `parity_err`  out  1: parity mismatch in the last frame; always 0 when `PARITY_MODE`=0.
- `frame_err`  out  1: a stop bit was sampled low in the last frame.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- One-hot FSM with states IDLE, START, DATA, PARITY, STOP. Any illegal encoding returns to IDLE on the next clock.
- Tick counter is `$clog2(OVERSAMPLE)` bits. Bit counter is `$clog2(N_DATA)+1` bits. Both advance only on cycles where `s_tick`=1.
- `armed` flag:
  - cleared by reset and by a frame error;
  - set on any cycle where `rx`=1 while in IDLE.
- IDLE:
  - if `armed` and `rx`=0, go to START with the tick counter at 0.
  - `s_tick` is not required for this transition.
- START: on the tick where the counter reaches `OVERSAMPLE/2-1`:
  - `rx`=0: go to DATA; clear both counters.
  - `rx`=1: glitch; return to IDLE with no pulse and no flag change.
- DATA:
  - On each tick where the counter reaches `OVERSAMPLE-1`: shift register ← {`rx`, sr[N_DATA-1:1]}, then reset the counter.
  - After the `N_DATA`-th sample, go to PARITY if `PARITY_MODE`≠0, otherwise go to STOP.
- PARITY:
  - Sample at `OVERSAMPLE-1`.
  - perr = ^sr ^ rx ^ (`PARITY_MODE`==2).
  - Go to STOP.
- STOP:
  - Sample `N_STOP` times, each at `OVERSAMPLE-1`.
  - Any low sample sets ferr.
  - After the last stop sample, go to IDLE.
- Frame completion: `rx_done_tick` pulses whether or not an error occurred. The cycle after the final stop sample:
  - `rx_done_tick`=1;
  - `dout` ← sr;
  - `parity_err` ← perr;
  - `frame_err` ← ferr.
- If ferr=1, `armed` is cleared, so a break condition produces exactly one `rx_done_tick` and no further frames until `rx` returns high.
- `dout`, `parity_err` and `frame_err` hold their values until the next completion.

## Timing
- Reset values: state IDLE; all counters 0; `dout`=0; `rx_done_tick`=0; `parity_err`=0; `frame_err`=0; `busy`=0; `armed`=0.
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced and the outputs take their reset values.
- All outputs are registered. `rx_done_tick` rises exactly one clock after the `s_tick` cycle that samples the last stop bit.
- Frame length from the start edge: OVERSAMPLE/2 + OVERSAMPLE·(N_DATA + P + N_STOP) ticks, where P = 1 when parity is enabled, else 0.
- `s_tick` arriving in the same cycle as the IDLE→START transition is not counted.
- Back-to-back frames: a start edge in the first IDLE cycle after STOP is accepted.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rx` passes through a two-flop synchronizer before the FSM.
  - The synchronizer resets to 1.
  - All `rx`-referenced timing is delayed by 2 clocks.
- `UART_RX_SYNC_EN` undefined: `rx` feeds the FSM directly. Use this only when `rx` is already synchronous.

## Structure
- Shared package `uart_pkg`:
  - one-hot state localparams and `NB_STATE`=5;
  - parity mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
- Sub-module `uart_rx_sync`: two-flop synchronizer with reset value 1, instantiated only under `UART_RX_SYNC_EN`.

## Test plan
All scenarios use `OVERSAMPLE`=16 with `s_tick` every 4 clocks.
- 8N1, frame 0xA5 → `dout`=0xA5; one `rx_done_tick`; both error flags 0; `busy` high for 152 ticks.
- 8E1 with 0x3C and parity bit 1 → `dout`=0x3C; `parity_err`=1. Resend with parity bit 0 → `parity_err`=0.
- 8N2, second stop bit low on 0x5A → `dout`=0x5A; `frame_err`=1; `rx_done_tick` once.
- 6-clock start glitch (shorter than 8 ticks) → FSM returns to IDLE; no `rx_done_tick`; outputs unchanged.
- Line held low for 30 bit times → exactly one `rx_done_tick` with `frame_err`=1 and `dout`=0x00. Release the line, then send 0x81 → `dout`=0x81 with no errors.
- Reset asserted during DATA bit 4 → all outputs 0 next cycle. The next clean frame 0xFF is received correctly.
